// File: rtl/q_credit_pkg.sv
// Shared pointer type and wrap helper for the credit-link queues (tx buffer and receive side).
package q_credit_pkg;

  // Fixed index width covers buffers up to 256 entries; users slice the low bits they need.
  localparam int unsigned PtrIdxW = 8;

  typedef struct packed {
    logic               msb;
    logic [PtrIdxW-1:0] index;
  } q_ptr_t;

  function automatic q_ptr_t ptr_inc(q_ptr_t ptr, int unsigned depth);
    q_ptr_t nxt;
    if (ptr.index == PtrIdxW'(depth - 1)) begin
      nxt.index = '0;
      nxt.msb   = ~ptr.msb;
    end else begin
      nxt.index = ptr.index + PtrIdxW'(1);
      nxt.msb   = ptr.msb;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/q_credit_tx_if.sv
// Upstream ready-valid and downstream credit link bundled for q_credit_tx.
interface q_credit_tx_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  credit_return;

  modport master (
    input  in_valid, in_data, credit_return,
    output in_ready, tx_valid, tx_data
  );

  modport slave (
    output in_valid, in_data, credit_return,
    input  in_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/q_credit_buf.sv
// Circular FIFO with {msb, index} pointers; depth need not be a power of two.
module q_credit_buf
  import q_credit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BUF_ENTRIES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int unsigned IdxW = $clog2(BUF_ENTRIES);

  logic [DATA_WIDTH-1:0] mem [BUF_ENTRIES];
  q_ptr_t wr_q, wr_d, rd_q, rd_d;
  logic   push_en, pop_en;

  assign full    = (wr_q.index == rd_q.index) && (wr_q.msb != rd_q.msb);
  assign empty   = (wr_q == rd_q);
  assign head    = mem[rd_q.index[IdxW-1:0]];
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  always_comb begin
    wr_d = push_en ? ptr_inc(wr_q, BUF_ENTRIES) : wr_q;
    rd_d = pop_en  ? ptr_inc(rd_q, BUF_ENTRIES) : rd_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_en) mem[wr_q.index[IdxW-1:0]] <= push_data;
  end

endmodule

// File: rtl/q_credit_tx.sv
// Credit-managed transmitter: buffers upstream beats and sends one per held credit.
// Define Q_CREDIT_TX_BYPASS_EN to let a beat skip an empty buffer (1-cycle latency).
module q_credit_tx
  import q_credit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_CREDITS    = 4,
  parameter int unsigned LOG_CREDIT_CNT = $clog2(NUM_CREDITS + 1),
  parameter int unsigned BUF_ENTRIES    = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  q_credit_tx_if.master             bus,
  output logic [LOG_CREDIT_CNT-1:0] credits_avail,
  output logic                      credit_err,
  output logic                      idle
);

  localparam logic [LOG_CREDIT_CNT-1:0] MaxCred = LOG_CREDIT_CNT'(NUM_CREDITS);

  logic                      buf_full, buf_empty;
  logic [DATA_WIDTH-1:0]     head;
  logic                      accept, bypass, push, pop, send, has_credit, saturate;
  logic                      tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;
  logic [LOG_CREDIT_CNT-1:0] cred_q, cred_d;
  logic                      err_q, err_d;

  q_credit_buf #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BUF_ENTRIES (BUF_ENTRIES)
  ) u_buf (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (pop),
    .full      (buf_full),
    .empty     (buf_empty),
    .head      (head)
  );

  assign bus.in_ready = ~buf_full & ~RST;

  always_comb begin
    has_credit = (cred_q != '0);
    accept     = bus.in_valid & bus.in_ready;
`ifdef Q_CREDIT_TX_BYPASS_EN
    bypass     = accept & buf_empty & has_credit;
`else
    bypass     = 1'b0;
`endif
    pop        = ~buf_empty & has_credit;
    push       = accept & ~bypass;
    send       = pop | bypass;
    tx_valid_d = send;
    tx_data_d  = pop ? head : (bypass ? bus.in_data : tx_data_q);
    // A return at full count with nothing spent has nowhere to go.
    saturate   = bus.credit_return & ~send & (cred_q == MaxCred);
    cred_d     = cred_q;
    if (send && !bus.credit_return) begin
      cred_d = cred_q - LOG_CREDIT_CNT'(1);
    end else if (!send && bus.credit_return && !saturate) begin
      cred_d = cred_q + LOG_CREDIT_CNT'(1);
    end
    err_d      = err_q | saturate;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cred_q     <= MaxCred;
      err_q      <= 1'b0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cred_q     <= cred_d;
      err_q      <= err_d;
    end
  end

  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign credits_avail = cred_q;
  assign credit_err    = err_q;
  assign idle          = buf_empty & ~tx_valid_q & (cred_q == MaxCred);

endmodule

// File: tb/tb_q_credit_tx.sv
// Bench for q_credit_tx: vector table, hand sequences and randomized traffic vs a queue model.
module tb_q_credit_tx;

  localparam int NA = 4;
  localparam int BA = 2;
`ifdef Q_CREDIT_TX_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       rst_a, rst_b;
  logic [2:0] cred_a;
  logic [1:0] cred_b;
  logic       err_a, err_b, idle_a, idle_b;

  q_credit_tx_if #(.DATA_WIDTH(32)) bus_a ();
  q_credit_tx_if #(.DATA_WIDTH(32)) bus_b ();

  q_credit_tx #(.DATA_WIDTH(32), .NUM_CREDITS(4), .BUF_ENTRIES(2)) dut_a (
    .CLK(CLK), .RST(rst_a), .bus(bus_a),
    .credits_avail(cred_a), .credit_err(err_a), .idle(idle_a)
  );

  q_credit_tx #(.DATA_WIDTH(32), .NUM_CREDITS(3), .BUF_ENTRIES(3)) dut_b (
    .CLK(CLK), .RST(rst_b), .bus(bus_b),
    .credits_avail(cred_b), .credit_err(err_b), .idle(idle_b)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model for dut_a: a FIFO of pending beats plus an integer credit count.
  int          mq[$];
  int          m_cred = NA;
  bit          m_txv  = 1'b0;
  logic [31:0] m_txd  = '0;
  bit          m_err  = 1'b0;

  task automatic tick_a(input bit rst, input bit iv, input logic [31:0] d, input bit cr);
    bit acc, snd, byp;
    rst_a = rst;
    bus_a.in_valid = iv;
    bus_a.in_data = d;
    bus_a.credit_return = cr;
    if (rst) begin
      mq.delete();
      m_cred = NA; m_txv = 1'b0; m_txd = '0; m_err = 1'b0;
    end else begin
      acc = iv && (mq.size() < BA);
      snd = (mq.size() > 0) && (m_cred > 0);
      byp = Byp && acc && (mq.size() == 0) && (m_cred > 0);
      if (snd) begin
        m_txd = mq.pop_front(); m_txv = 1'b1;
      end else if (byp) begin
        m_txd = d; m_txv = 1'b1;
      end else begin
        m_txv = 1'b0;
      end
      if (acc && !byp) mq.push_back(int'(d));
      m_cred = m_cred - int'(snd || byp) + int'(cr);
      if (m_cred > NA) begin
        m_cred = NA; m_err = 1'b1;
      end
    end
    @(posedge CLK); #1;
    chk("model tx_valid", 32'(bus_a.tx_valid), 32'(m_txv));
    if (m_txv) chk("model tx_data", bus_a.tx_data, m_txd);
    chk("model credits", 32'(cred_a), 32'(m_cred));
    chk("model in_ready", 32'(bus_a.in_ready), 32'(!rst && (mq.size() < BA)));
    chk("model credit_err", 32'(err_a), 32'(m_err));
    chk("model idle", 32'(idle_a),
        32'((mq.size() == 0) && !m_txv && (m_cred == NA)));
  endtask

  task automatic tick_b(input bit rst, input bit iv, input logic [31:0] d, input bit cr);
    rst_b = rst;
    bus_b.in_valid = iv;
    bus_b.in_data = d;
    bus_b.credit_return = cr;
    @(posedge CLK); #1;
  endtask

  typedef struct {
    bit          rst;
    bit          iv;
    logic [31:0] d;
    bit          cr;
    bit          e_txv;
    logic [31:0] e_txd;
    int          e_cred;
    bit          e_rdy;
  } vec_t;

  vec_t vec[12];

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      tick_a(vec[i].rst, vec[i].iv, vec[i].d, vec[i].cr);
      chk($sformatf("vec%0d tx_valid", i), 32'(bus_a.tx_valid), 32'(vec[i].e_txv));
      chk($sformatf("vec%0d tx_data", i), bus_a.tx_data, vec[i].e_txd);
      chk($sformatf("vec%0d credits", i), 32'(cred_a), 32'(vec[i].e_cred));
      chk($sformatf("vec%0d in_ready", i), 32'(bus_a.in_ready), 32'(vec[i].e_rdy));
    end
  endtask

  initial begin
    int sent, rcvd;
    bit txv_cur, txv_prev, acc;

    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.credit_return = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.credit_return = 1'b0;

    // Rows: rst iv data cr | tx_valid tx_data credits in_ready
    vec[0]  = '{1, 0, 32'h00, 0, 0, 32'h00, 4, 0};
    vec[1]  = '{0, 0, 32'h00, 0, 0, 32'h00, 4, 1};
`ifdef Q_CREDIT_TX_BYPASS_EN
    vec[2]  = '{0, 1, 32'hA0, 0, 1, 32'hA0, 3, 1};
    vec[3]  = '{0, 1, 32'hA1, 0, 1, 32'hA1, 2, 1};
    vec[4]  = '{0, 1, 32'hA2, 0, 1, 32'hA2, 1, 1};
    vec[5]  = '{0, 1, 32'hA3, 0, 1, 32'hA3, 0, 1};
    vec[6]  = '{0, 1, 32'hA4, 0, 0, 32'hA3, 0, 1};
`else
    vec[2]  = '{0, 1, 32'hA0, 0, 0, 32'h00, 4, 1};
    vec[3]  = '{0, 1, 32'hA1, 0, 1, 32'hA0, 3, 1};
    vec[4]  = '{0, 1, 32'hA2, 0, 1, 32'hA1, 2, 1};
    vec[5]  = '{0, 1, 32'hA3, 0, 1, 32'hA2, 1, 1};
    vec[6]  = '{0, 1, 32'hA4, 0, 1, 32'hA3, 0, 1};
`endif
    vec[7]  = '{0, 1, 32'hA5, 0, 0, 32'hA3, 0, 0};
    vec[8]  = '{0, 0, 32'h00, 0, 0, 32'hA3, 0, 0};
    vec[9]  = '{0, 0, 32'h00, 1, 0, 32'hA3, 1, 0};
    vec[10] = '{0, 0, 32'h00, 0, 1, 32'hA4, 0, 1};
    vec[11] = '{0, 0, 32'h00, 0, 0, 32'hA4, 0, 1};

    // Push A0..A5 with no returns, then one returned credit releases A4.
    run_rows(0, 11);

    // Reset with two beats buffered and one credit held: nothing stale may leave.
    run_rows(0, 9);
    tick_a(1'b1, 1'b1, 32'hEE, 1'b1);
    chk("rst tx_valid", 32'(bus_a.tx_valid), 32'd0);
    chk("rst credits", 32'(cred_a), 32'd4);
    chk("rst in_ready", 32'(bus_a.in_ready), 32'd0);
    tick_a(1'b0, 1'b0, 32'h0, 1'b0);
    chk("post-rst in_ready", 32'(bus_a.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick_a(1'b0, 1'b0, 32'h0, 1'b0);
      chk("post-rst stale beat", 32'(bus_a.tx_valid), 32'd0);
    end

    // Credit returned while idle at full count: sticky error until reset.
    tick_a(1'b0, 1'b0, 32'h0, 1'b1);
    chk("overflow err", 32'(err_a), 32'd1);
    chk("overflow credits", 32'(cred_a), 32'd4);
    chk("overflow idle", 32'(idle_a), 32'd1);
    for (int i = 0; i < 3; i++) tick_a(1'b0, 1'b0, 32'h0, 1'b0);
    chk("err sticky", 32'(err_a), 32'd1);
    tick_a(1'b1, 1'b0, 32'h0, 1'b0);
    chk("err cleared", 32'(err_a), 32'd0);
    tick_a(1'b0, 1'b0, 32'h0, 1'b0);

    // Single-beat latency into an idle block.
    tick_a(1'b0, 1'b1, 32'h5A, 1'b0);
    chk("lat a accept+1", 32'(bus_a.tx_valid), 32'(Byp));
    tick_a(1'b0, 1'b0, 32'h0, 1'b0);
    chk("lat a accept+2", 32'(bus_a.tx_valid), 32'(!Byp));
    chk("lat a data", bus_a.tx_data, 32'h5A);

    // Randomized traffic, returns and occasional reset against the model.
    for (int i = 0; i < 400; i++) begin
      tick_a($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, $urandom,
             $urandom_range(0, 2) == 0);
    end

    // dut_b: 3 credits, 3 entries; returns follow tx_valid by one cycle.
    tick_b(1'b1, 1'b0, 32'h0, 1'b0);
    tick_b(1'b0, 1'b0, 32'h0, 1'b0);
    chk("b reset credits", 32'(cred_b), 32'd3);
    chk("b reset idle", 32'(idle_b), 32'd1);
    sent = 0; rcvd = 0; txv_cur = 1'b0; txv_prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      acc = (sent < 20) && bus_b.in_ready;
      tick_b(1'b0, sent < 20, 32'h100 + 32'(sent), txv_prev);
      if (acc) sent++;
      if (bus_b.tx_valid) begin
        chk("b stream order", bus_b.tx_data, 32'h100 + 32'(rcvd));
        rcvd++;
      end
      txv_prev = txv_cur;
      txv_cur  = bus_b.tx_valid;
    end
    chk("b beat count", 32'(rcvd), 32'd20);
    chk("b no credit_err", 32'(err_b), 32'd0);
    chk("b final credits", 32'(cred_b), 32'd3);
    chk("b final idle", 32'(idle_b), 32'd1);

    tick_b(1'b0, 1'b1, 32'h5A, 1'b0);
    chk("lat b accept+1", 32'(bus_b.tx_valid), 32'(Byp));
    tick_b(1'b0, 1'b0, 32'h0, 1'b0);
    chk("lat b accept+2", 32'(bus_b.tx_valid), 32'(!Byp));
    chk("lat b data", bus_b.tx_data, 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
